uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO, runtime-configurable word length, parity and stop bits. It is intended to sit behind the GPMC register bank. Control and configuration come from register bits; status (empty, full, count, busy, overflow) is read back through the same bank. Software can queue several words and let them drain autonomously at the programmed baud rate.

---
 rtl/uart_tx_fifo.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO; frame format (width, parity, stop bits, baud)
// is latched from the configuration inputs each time a word is popped.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [4:0]            bits_per_word,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [FIFO_AW:0]      fifo_count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned BW    = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [FIFO_AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         nbits_q, nbits_d, bitcnt_q, bitcnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d, baud_q, baud_d;
  logic [1:0]            pmode_q, pmode_d;
  logic                  two_stop_q, two_stop_d, stop2_q, stop2_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                  push_c, pop_c, par_en_c, bit_end_c;
  logic [BW-1:0]         nbits_in_c;
  logic [DIV_WIDTH-1:0]  div_in_c;

  // FIFO: a write while full is still accepted when the head is popped that cycle
  always_comb begin
    pop_c   = (state_q == S_IDLE) && en && !empty_q;
    push_c  = wr_en && (!full_q || pop_c);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    ovf_d   = ovf_q;
    if (push_c) begin
      mem_d[wptr_q] = data_in;
      wptr_d        = wptr_q + FIFO_AW'(1);
    end
    if (pop_c) begin
      rptr_d = rptr_q + FIFO_AW'(1);
    end
    if (wr_en && full_q && !pop_c) begin
      ovf_d = 1'b1;
    end
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  // Frame sequencer; tx/busy/done are computed one cycle ahead so they can be registered
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    nbits_d    = nbits_q;
    bitcnt_d   = bitcnt_q;
    div_d      = div_q;
    pmode_d    = pmode_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    par_d      = par_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    par_en_c   = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    bit_end_c  = (baud_q == '0);
    nbits_in_c = (bits_per_word == '0) ? BW'(1) :
                 (32'(bits_per_word) > DATA_WIDTH) ? BW'(DATA_WIDTH) : bits_per_word;
    div_in_c   = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;

    baud_d = baud_q;
    if (state_q != S_IDLE) begin
      baud_d = bit_end_c ? (div_q - DIV_WIDTH'(1)) : (baud_q - DIV_WIDTH'(1));
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (pop_c) begin
          shift_d    = mem_q[rptr_q];
          nbits_d    = nbits_in_c;
          div_d      = div_in_c;
          pmode_d    = parity_mode;
          two_stop_d = two_stop;
          baud_d     = div_in_c - DIV_WIDTH'(1);
          bitcnt_d   = '0;
          par_d      = 1'b0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (bitcnt_q == nbits_q - BW'(1)) begin
            if (par_en_c) begin
              tx_d    = par_q ^ shift_q[0] ^ (pmode_q == 2'b10);
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              stop2_d = two_stop_q;
              state_d = S_STOP;
            end
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
            tx_d     = shift_d[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          tx_d    = 1'b1;
          stop2_d = two_stop_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (stop2_q) begin
            stop2_d = 1'b0;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      shift_q    <= '0;
      nbits_q    <= '0;
      bitcnt_q   <= '0;
      div_q      <= '0;
      baud_q     <= '0;
      pmode_q    <= '0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      shift_q    <= shift_d;
      nbits_q    <= nbits_d;
      bitcnt_q   <= bitcnt_d;
      div_q      <= div_d;
      baud_q     <= baud_d;
      pmode_q    <= pmode_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frame table, corner sequences and random traffic
// checked cycle by cycle against a queue-based frame model.
module tb_uart_tx_fifo;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          en;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic [4:0]    bits_per_word;
  logic [15:0]   clk_div;
  logic [1:0]    parity_mode;
  logic          two_stop;
  logic          tx;
  logic          busy;
  logic          done;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
  logic          overflow;

  uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_AW(AW), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .data_in(data_in),
    .bits_per_word(bits_per_word), .clk_div(clk_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .tx(tx), .busy(busy), .done(done),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [4:0]  bpw;
    logic [15:0] div;
    logic [1:0]  pm;
    logic        ts;
    int          exp_len;
    int          par_idx;
    logic        exp_par;
    logic [63:0] exp_line;
  } vec_t;

  vec_t vecs[9];

  int n_cmp;
  int n_fail;
  int n_done;

  // reference model state
  logic [15:0]  mq[$];
  logic         m_ovf, m_in_frame, m_cyc_busy, m_done_next, m_busy_bad, armed;
  int           m_pos, m_len;
  logic [255:0] m_exp, m_act;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected tx waveform of one frame, one entry per clock cycle
  function automatic void build(input logic [15:0] w, input logic [4:0] bpw,
                                input logic [15:0] dv, input logic [1:0] pm, input logic ts,
                                output logic [255:0] v, output int len);
    int   n, d;
    logic b[$];
    logic p;
    n = (bpw == 0) ? 1 : ((int'(bpw) > DW) ? DW : int'(bpw));
    d = (dv == 0) ? 1 : int'(dv);
    p = 1'b0;
    b.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      b.push_back(w[i]);
      p ^= w[i];
    end
    if (pm == 2'd1) b.push_back(p);
    else if (pm == 2'd2) b.push_back(~p);
    b.push_back(1'b1);
    if (ts) b.push_back(1'b1);
    v   = '0;
    len = 0;
    foreach (b[i]) begin
      for (int k = 0; k < d; k++) begin
        v[len] = b[i];
        len++;
      end
    end
  endfunction

  // Advance the model by the posedge just passed and check the cycle now visible
  task automatic mon_step();
    logic pop_exp;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_in_frame = 1'b0; m_cyc_busy = 1'b0; m_done_next = 1'b0;
      armed = 1'b1;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      return;
    end
    if (!armed) return;
    pop_exp = !m_cyc_busy && en && (mq.size() > 0);
    if (pop_exp) begin
      build(mq.pop_front(), bits_per_word, clk_div, parity_mode, two_stop, m_exp, m_len);
      m_act = '0; m_pos = 0; m_in_frame = 1'b1; m_busy_bad = 1'b0;
    end
    if (wr_en) begin
      if (mq.size() < DEPTH) mq.push_back(data_in);
      else m_ovf = 1'b1;
    end
    chk("done", done, m_done_next);
    m_done_next = 1'b0;
    if (m_in_frame) begin
      m_act[m_pos] = tx;
      if (busy !== 1'b1) m_busy_bad = 1'b1;
      m_pos++;
      m_cyc_busy = 1'b1;
      if (m_pos == m_len) begin
        chk("frame", m_act, m_exp);
        chk("frame_busy", m_busy_bad, 0);
        m_in_frame  = 1'b0;
        m_done_next = 1'b1;
      end
    end else begin
      m_cyc_busy = 1'b0;
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
    end
    chk("count", fifo_count, mq.size());
    chk("empty", fifo_empty, mq.size() == 0);
    chk("full", fifo_full, mq.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    mon_step();
    if (done === 1'b1) n_done++;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((fifo_empty !== 1'b1 || busy !== 1'b0) && t < 3000) begin
      tick();
      t++;
    end
    chk("drain_timeout", t < 3000, 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int           t, len;
    logic [255:0] line;
    bits_per_word = v.bpw; clk_div = v.div; parity_mode = v.pm; two_stop = v.ts; en = 1'b1;
    wr_en = 1'b1; data_in = v.word;
    tick();
    wr_en = 1'b0;
    t = 0;
    while (busy !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk($sformatf("v%0d_start", idx), t < 20, 1);
    chk($sformatf("v%0d_empty_after_pop", idx), fifo_empty, 1);
    line = '0;
    len  = 0;
    while (busy === 1'b1 && len < 300) begin
      line[len] = tx;
      len++;
      tick();
    end
    chk($sformatf("v%0d_len", idx), len, v.exp_len);
    chk($sformatf("v%0d_line", idx), line[63:0], v.exp_line);
    chk($sformatf("v%0d_done", idx), done, 1);
    if (v.par_idx >= 0) chk($sformatf("v%0d_parity", idx), line[v.par_idx], v.exp_par);
  endtask

  initial begin
    int t, len, d0, bcnt;
    n_cmp = 0; n_fail = 0; n_done = 0;
    armed = 1'b0; m_ovf = 1'b0; m_in_frame = 1'b0; m_cyc_busy = 1'b0;
    m_done_next = 1'b0; m_busy_bad = 1'b0; m_pos = 0; m_len = 0;
    m_exp = '0; m_act = '0;

    vecs[0] = '{16'h0055, 5'd8,  16'd4, 2'd0, 1'b0, 40, -1, 1'b0, 64'hF0F0F0F0F0};
    vecs[1] = '{16'h0007, 5'd8,  16'd4, 2'd1, 1'b0, 44, 36, 1'b1, 64'hFF00000FFF0};
    vecs[2] = '{16'h0007, 5'd8,  16'd4, 2'd2, 1'b0, 44, 36, 1'b0, 64'hF000000FFF0};
    vecs[3] = '{16'h0007, 5'd8,  16'd4, 2'd1, 1'b1, 48, 36, 1'b1, 64'hFFF00000FFF0};
    vecs[4] = '{16'hA5C3, 5'd16, 16'd1, 2'd0, 1'b0, 18, -1, 1'b0, 64'h34B86};
    vecs[5] = '{16'h0002, 5'd0,  16'd0, 2'd3, 1'b0, 3,  -1, 1'b0, 64'h4};
    vecs[6] = '{16'h8001, 5'd31, 16'd2, 2'd2, 1'b0, 38, 34, 1'b1, 64'h3F0000000C};
    vecs[7] = '{16'h0001, 5'd1,  16'd3, 2'd2, 1'b1, 15, 6,  1'b0, 64'h7E38};
    vecs[8] = '{16'h00FF, 5'd5,  16'd1, 2'd1, 1'b0, 8,  6,  1'b1, 64'hFE};

    rst = 1'b1; en = 1'b0; wr_en = 1'b0; data_in = '0;
    bits_per_word = 5'd8; clk_div = 16'd4; parity_mode = 2'd0; two_stop = 1'b0;
    tick();
    tick();
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_empty", fifo_empty, 1);
    chk("reset_full", fifo_full, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // clk_div changed mid-frame must not stretch the frame already started
    bits_per_word = 5'd8; clk_div = 16'd2; parity_mode = 2'd0; two_stop = 1'b0; en = 1'b1;
    wr_en = 1'b1; data_in = 16'h003C;
    tick();
    wr_en = 1'b0;
    t = 0;
    while (busy !== 1'b1 && t < 20) begin tick(); t++; end
    len = 0;
    while (busy === 1'b1 && len < 300) begin
      if (len == 3) clk_div = 16'd5;
      len++;
      tick();
    end
    chk("div_midframe_len", len, 20);

    // fill past full with transmit disabled, then release
    bits_per_word = 5'd16; clk_div = 16'd1; en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; data_in = 16'(32'h1000 + i);
      tick();
      if (i == 15) begin
        chk("full_at_16", fifo_full, 1);
        chk("count_at_16", fifo_count, 16);
        chk("no_ovf_at_16", overflow, 0);
      end
    end
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("count_after_drop", fifo_count, 16);
    d0 = n_done;
    en = 1'b1;
    drain();
    chk("ovf_frames", n_done - d0, 16);
    chk("ovf_sticky", overflow, 1);

    // twenty 16-bit words interleaved with drains, wrapping the pointers
    d0 = n_done;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; data_in = 16'hA5C3;
      tick();
      wr_en = 1'b0;
      if (i % 5 == 4) drain();
      else tick();
    end
    drain();
    chk("wrap_frames", n_done - d0, 20);

    // reset during DATA with three words still queued
    en = 1'b0; clk_div = 16'd4; bits_per_word = 5'd8;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; data_in = 16'(32'h2000 + i);
      tick();
    end
    wr_en = 1'b0;
    en = 1'b1;
    t = 0;
    while (!(fifo_count == 3 && busy === 1'b1) && t < 2000) begin tick(); t++; end
    chk("reach_three_left", t < 2000, 1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_empty", fifo_empty, 1);
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b0) bcnt++;
    end
    chk("midrst_no_frame", bcnt, 0);

    // random traffic with occasional config changes, enable toggles and resets
    for (int i = 0; i < 4000; i++) begin
      wr_en   = ($urandom_range(0, 99) < 30);
      data_in = 16'($urandom);
      if ($urandom_range(0, 99) < 3) en = ~en;
      if ($urandom_range(0, 99) < 4) begin
        bits_per_word = 5'($urandom_range(0, 31));
        clk_div       = 16'($urandom_range(0, 4));
        parity_mode   = 2'($urandom_range(0, 3));
        two_stop      = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; wr_en = 1'b0; en = 1'b1;
    drain();
    chk("final_empty", fifo_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
